// File: rtl/fproc_arb_pkg.sv
// -----------------------------------------------------------------------------
// fproc_arb_pkg
//   Shared types and helpers for the function-processor arbiter:
//     state_e          - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//     TIMEOUT_FILL_BIT - bit replicated across the response data on timeout
//     core_idx_width() - width of a core index for a given core count
// -----------------------------------------------------------------------------
package fproc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // A timed-out transaction returns all ones to the waiting core.
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

    function automatic int unsigned core_idx_width(input int unsigned n_cores);
        return (n_cores > 1) ? $clog2(n_cores) : 1;
    endfunction

endpackage

// File: rtl/fproc_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: selects the first set bit of pending_i
//   at or after rr_ptr_i, wrapping past N-1 back to 0.
//   Ports:
//     pending_i   [N]  - request vector
//     rr_ptr_i    [IW] - index with the highest priority this round
//     grant_o     [IW] - selected index (0 when nothing is pending)
//     any_valid_o      - at least one pending bit is set
// -----------------------------------------------------------------------------
module rr_pick
    import fproc_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = core_idx_width(N)
) (
    input  logic [N-1:0]  pending_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_valid_o
);

    int unsigned idx;

    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        // Walk offsets from farthest to nearest; the last hit is the index
        // closest to the pointer, so it overrides the earlier ones.
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr_i) + N - 1 - k) % N;
            if (pending_i[IW'(idx)]) begin
                grant_o     = IW'(idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fproc_arb.sv
// -----------------------------------------------------------------------------
// fproc_arb
//   Shares one function-processor (fproc) port among N_CORES cores. Each
//   core request (core_req + core_id slice) is latched as pending, picked
//   round-robin, issued downstream one transaction at a time, and the
//   response is handed back to the requesting core as a one-cycle strobe.
//   A response timeout returns all-ones data so a dead fproc cannot hang
//   a core.
//   Ports:
//     clk, reset (async, active low)
//     core_req   [N]       - per-core request pulse
//     core_id    [N*IDW]   - per-core request id, sampled with core_req
//     core_ready [N]       - one-hot response strobe (RESP cycle only)
//     core_data  [DW]      - response data, 0 unless a core_ready bit is high
//     fp_req_valid/ready   - downstream request handshake
//     fp_req_id  [IDW]     - id of the issued request
//     fp_req_core          - index of the issuing core
//     fp_resp_valid/data   - downstream response strobe and data
//     timeout_err          - sticky, set on any response timeout
//     proto_err            - sticky, set on a repeat request from a pending
//                            core or on fp_resp_valid outside WAIT
// -----------------------------------------------------------------------------
module fproc_arb
    import fproc_arb_pkg::*;
#(
    parameter int unsigned N_CORES        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FPROC_ID_WIDTH = 8,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_CORES-1:0]                core_req,
    input  logic [N_CORES*FPROC_ID_WIDTH-1:0] core_id,
    output logic [N_CORES-1:0]                core_ready,
    output logic [DATA_WIDTH-1:0]             core_data,
    output logic                              fp_req_valid,
    input  logic                              fp_req_ready,
    output logic [FPROC_ID_WIDTH-1:0]         fp_req_id,
    output logic [$clog2(N_CORES)-1:0]        fp_req_core,
    input  logic                              fp_resp_valid,
    input  logic [DATA_WIDTH-1:0]             fp_resp_data,
    output logic                              timeout_err,
    output logic                              proto_err
);

    localparam int unsigned IW = core_idx_width(N_CORES);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [N_CORES-1:0] ONE_HOT0 = {{(N_CORES-1){1'b0}}, 1'b1};

    state_e                    state_q, state_d;
    logic [N_CORES-1:0]        pending_q, pending_d;
    logic [FPROC_ID_WIDTH-1:0] id_q [N_CORES];
    logic [FPROC_ID_WIDTH-1:0] id_d [N_CORES];
    logic [IW-1:0]             cur_q, cur_d;
    logic [IW-1:0]             rr_q, rr_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      terr_q, terr_d;
    logic                      perr_q, perr_d;

    logic [N_CORES-1:0]        clr;
    logic [IW-1:0]             grant;
    logic                      any_pending;

    rr_pick #(
        .N (N_CORES)
    ) u_pick (
        .pending_i   (pending_q),
        .rr_ptr_i    (rr_q),
        .grant_o     (grant),
        .any_valid_o (any_pending)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            for (int unsigned i = 0; i < N_CORES; i++) begin
                id_q[i] <= '0;
            end
            cur_q     <= '0;
            rr_q      <= '0;
            timer_q   <= '0;
            data_q    <= '0;
            terr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int unsigned i = 0; i < N_CORES; i++) begin
                id_q[i] <= id_d[i];
            end
            cur_q     <= cur_d;
            rr_q      <= rr_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            terr_q    <= terr_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        id_d      = id_q;
        cur_d     = cur_q;
        rr_d      = rr_q;
        timer_d   = timer_q;
        data_d    = data_q;
        terr_d    = terr_q;
        perr_d    = perr_q;

        core_ready   = '0;
        core_data    = '0;
        fp_req_valid = 1'b0;
        fp_req_id    = '0;
        fp_req_core  = '0;

        // The core being answered this cycle frees its pending slot at the
        // coming edge, so a fresh request from it is legal right now.
        clr = (state_q == RESP) ? (ONE_HOT0 << cur_q) : '0;

        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (core_req[i]) begin
                if (pending_q[i] && !clr[i]) begin
                    perr_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    id_d[i]      = core_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
                end
            end else if (clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        if (fp_resp_valid && state_q != WAIT) begin
            perr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (any_pending) begin
                    cur_d   = grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fp_req_valid = 1'b1;
                fp_req_id    = id_q[cur_q];
                fp_req_core  = cur_q;
                if (fp_req_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response landing on the timeout cycle takes priority.
                if (fp_resp_valid) begin
                    data_d  = fp_resp_data;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    data_d  = {DATA_WIDTH{TIMEOUT_FILL_BIT}};
                    terr_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                core_ready = ONE_HOT0 << cur_q;
                core_data  = data_q;
                rr_d       = (cur_q == IW'(N_CORES - 1)) ? '0 : cur_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign timeout_err = terr_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_fproc_arb.sv
`timescale 1ns/1ps
module tb_fproc_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 8;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  core_req;
    logic [N*FW-1:0] core_id;
    logic [N-1:0]  core_ready;
    logic [DW-1:0] core_data;
    logic          fp_req_valid;
    logic          fp_req_ready;
    logic [FW-1:0] fp_req_id;
    logic [1:0]    fp_req_core;
    logic          fp_resp_valid;
    logic [DW-1:0] fp_resp_data;
    logic          timeout_err;
    logic          proto_err;

    fproc_arb #(
        .N_CORES        (N),
        .DATA_WIDTH     (DW),
        .FPROC_ID_WIDTH (FW),
        .TIMEOUT        (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_req      (core_req),
        .core_id       (core_id),
        .core_ready    (core_ready),
        .core_data     (core_data),
        .fp_req_valid  (fp_req_valid),
        .fp_req_ready  (fp_req_ready),
        .fp_req_id     (fp_req_id),
        .fp_req_core   (fp_req_core),
        .fp_resp_valid (fp_resp_valid),
        .fp_resp_data  (fp_resp_data),
        .timeout_err   (timeout_err),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          edge_n   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic set_req(input int unsigned c, input logic [FW-1:0] id);
        core_req[c]        = 1'b1;
        core_id[c*FW +: FW] = id;
    endtask

    function automatic logic [N-1:0] onehot(input int unsigned c);
        logic [N-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        reset         = 1'b0;
        core_req      = '0;
        core_id       = '0;
        fp_req_ready  = 1'b0;
        fp_resp_valid = 1'b0;
        fp_resp_data  = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Wait for a core_ready pulse; t is the number of edges taken.
    task automatic wait_ready(input int unsigned budget, output int unsigned t);
        t = 0;
        do begin
            tick();
            t++;
        end while (core_ready == '0 && t < budget);
    endtask

    // ---------------- table-driven single-request vectors ----------------
    typedef struct {
        int unsigned   core;
        logic [FW-1:0] id;
        int unsigned   delay;     // edges after acceptance; 0 = no response
        logic [DW-1:0] resp;
        logic [DW-1:0] exp_data;
        int unsigned   exp_lat;
        logic          exp_terr;
    } vec_t;

    vec_t vecs [5];

    // ---------------- random-test reference model state ----------------
    logic [N-1:0]  m_pend;
    logic [FW-1:0] m_id [N];
    int            m_latch [N];
    int unsigned   m_rr;
    bit            in_issue, have_exp, exp_to, resp_sched, prev_v, found;
    int unsigned   cur, exp_core, exp_c, served;
    int            exp_edge, resp_edge;
    logic [DW-1:0] exp_data, resp_val;
    logic          exp_terr, exp_perr;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned   t, seen, n_iss, d, cc;
        logic [N-1:0]  got_rdy, exp_rdy;
        logic [DW-1:0] got_dat, exp_dat;
        logic [FW-1:0] nid;
        int unsigned   order [4];
        logic [FW-1:0] oids [4];
        int unsigned   exp_order [4];
        logic [FW-1:0] exp_oids [4];
        bit            reinj, resp_next;

        vecs[0] = '{core: 2, id: 8'h15, delay: 3,  resp: 32'hDEADBEEF, exp_data: 32'hDEADBEEF, exp_lat: 3,  exp_terr: 1'b0};
        vecs[1] = '{core: 0, id: 8'hA5, delay: 1,  resp: 32'h12345678, exp_data: 32'h12345678, exp_lat: 1,  exp_terr: 1'b0};
        vecs[2] = '{core: 3, id: 8'h3C, delay: TO, resp: 32'hCAFEF00D, exp_data: 32'hCAFEF00D, exp_lat: TO, exp_terr: 1'b0};
        vecs[3] = '{core: 1, id: 8'h7E, delay: 0,  resp: 32'h0,        exp_data: 32'hFFFFFFFF, exp_lat: TO, exp_terr: 1'b1};
        vecs[4] = '{core: 2, id: 8'h01, delay: 2,  resp: 32'h00000000, exp_data: 32'h00000000, exp_lat: 2,  exp_terr: 1'b1};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_outputs",
              {core_ready, core_data, fp_req_valid, fp_req_id, fp_req_core, timeout_err, proto_err}, '0);

        // ---------------- table vectors ----------------
        fp_req_ready = 1'b1;
        foreach (vecs[v]) begin
            set_req(vecs[v].core, vecs[v].id);
            tick();
            core_req = '0;
            check("vec_valid_k1", fp_req_valid, 1'b0);
            tick();
            check("vec_issue", {fp_req_valid, fp_req_id, fp_req_core},
                  {1'b1, vecs[v].id, 2'(vecs[v].core)});
            tick();
            check("vec_accepted", fp_req_valid, 1'b0);
            t = 0;
            got_rdy = '0;
            got_dat = '0;
            while (t < TO + 2 && got_rdy == '0) begin
                t++;
                if (t == vecs[v].delay) begin
                    fp_resp_valid = 1'b1;
                    fp_resp_data  = vecs[v].resp;
                end
                tick();
                fp_resp_valid = 1'b0;
                got_rdy = core_ready;
                got_dat = core_data;
            end
            check("vec_latency", t, vecs[v].exp_lat);
            check("vec_ready", got_rdy, onehot(vecs[v].core));
            check("vec_data", got_dat, vecs[v].exp_data);
            check("vec_terr", timeout_err, vecs[v].exp_terr);
            tick();
            check("vec_ready_after", {core_ready, core_data}, '0);
        end

        // ---------------- simultaneous requests, rr respected ----------------
        do_reset();
        fp_req_ready = 1'b1;
        set_req(0, 8'h10);
        set_req(1, 8'h11);
        set_req(3, 8'h13);
        tick();
        core_req  = '0;
        n_iss     = 0;
        reinj     = 1'b0;
        resp_next = 1'b0;
        prev_v    = 1'b0;
        exp_order = '{0, 1, 3, 0};
        exp_oids  = '{8'h10, 8'h11, 8'h13, 8'h20};
        for (int unsigned c = 0; c < 80 && n_iss < 4; c++) begin
            fp_resp_valid = 1'b0;
            core_req      = '0;
            if (fp_req_valid && !prev_v) begin
                order[n_iss] = fp_req_core;
                oids[n_iss]  = fp_req_id;
                n_iss++;
            end
            prev_v = fp_req_valid;
            if (resp_next) begin
                fp_resp_valid = 1'b1;
                fp_resp_data  = 32'h0000_1000 + c;
                resp_next     = 1'b0;
            end
            if (fp_req_valid) resp_next = 1'b1;
            if (core_ready[0] && !reinj) begin
                set_req(0, 8'h20);
                reinj = 1'b1;
            end
            tick();
        end
        fp_resp_valid = 1'b0;
        core_req      = '0;
        check("sim_issue_count", n_iss, 4);
        for (int unsigned i = 0; i < 4; i++) begin
            check("sim_order", order[i], exp_order[i]);
            check("sim_id", oids[i], exp_oids[i]);
        end
        check("sim_no_proto", proto_err, 1'b0);

        // ---------------- backpressure ----------------
        do_reset();
        set_req(1, 8'h5A);
        tick();
        core_req = '0;
        tick();
        check("bp_issue", {fp_req_valid, fp_req_id, fp_req_core}, {1'b1, 8'h5A, 2'd1});
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {fp_req_valid, fp_req_id, fp_req_core, core_ready}, {1'b1, 8'h5A, 2'd1, 4'b0});
        end
        check("bp_no_timeout", timeout_err, 1'b0);
        fp_req_ready = 1'b1;
        tick();
        fp_req_ready = 1'b0;
        check("bp_accepted", fp_req_valid, 1'b0);
        wait_ready(TO + 4, t);
        check("bp_wait_from_accept", t, TO);
        check("bp_ready", core_ready, 4'b0010);

        // ---------------- timeout then next core ----------------
        do_reset();
        fp_req_ready = 1'b1;
        set_req(1, 8'h31);
        set_req(2, 8'h32);
        tick();
        core_req = '0;
        tick();
        check("to_issue_first", {fp_req_valid, fp_req_core}, {1'b1, 2'd1});
        tick();
        wait_ready(TO + 4, t);
        check("to_latency", t, TO);
        check("to_ready", core_ready, 4'b0010);
        check("to_data", core_data, 32'hFFFFFFFF);
        check("to_err", timeout_err, 1'b1);
        t = 0;
        do begin
            tick();
            t++;
        end while (!fp_req_valid && t < 6);
        check("to_next_issue", {fp_req_valid, fp_req_id, fp_req_core}, {1'b1, 8'h32, 2'd2});
        tick();
        fp_resp_valid = 1'b1;
        fp_resp_data  = 32'h600DCAFE;
        tick();
        fp_resp_valid = 1'b0;
        check("to_next_ready", {core_ready, core_data}, {4'b0100, 32'h600DCAFE});
        check("to_err_sticky", timeout_err, 1'b1);

        // ---------------- protocol errors ----------------
        do_reset();
        fp_resp_valid = 1'b1;
        fp_resp_data  = 32'h1;
        tick();
        fp_resp_valid = 1'b0;
        check("perr_stray", proto_err, 1'b1);
        check("perr_stray_quiet", {core_ready, fp_req_valid}, '0);
        tick();
        check("perr_stray_quiet2", {core_ready, fp_req_valid}, '0);

        do_reset();
        set_req(3, 8'h77);
        tick();
        core_req = '0;
        check("perr_first_ok", proto_err, 1'b0);
        tick();
        check("perr_issue", {fp_req_valid, fp_req_id}, {1'b1, 8'h77});
        set_req(3, 8'h88);
        tick();
        core_req = '0;
        check("perr_repeat", proto_err, 1'b1);
        check("perr_id_kept", fp_req_id, 8'h77);
        fp_req_ready = 1'b1;
        tick();
        fp_req_ready  = 1'b0;
        fp_resp_valid = 1'b1;
        fp_resp_data  = 32'h00001357;
        tick();
        fp_resp_valid = 1'b0;
        check("perr_served", {core_ready, core_data}, {4'b1000, 32'h00001357});
        seen = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            tick();
            if (core_ready != '0 || fp_req_valid) seen++;
        end
        check("perr_no_dup", seen, 0);

        // ---------------- async reset mid-WAIT ----------------
        do_reset();
        fp_req_ready = 1'b1;
        set_req(1, 8'h41);
        tick();
        core_req = '0;
        tick();
        tick();
        fp_resp_valid = 1'b1;
        fp_resp_data  = 32'h41414141;
        tick();
        fp_resp_valid = 1'b0;
        check("ar_pre_ready", core_ready, 4'b0010);
        set_req(2, 8'h42);
        tick();
        core_req = '0;
        tick();
        check("ar_issue2", {fp_req_valid, fp_req_core}, {1'b1, 2'd2});
        tick();
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        check("ar_outputs_zero",
              {core_ready, core_data, fp_req_valid, fp_req_id, fp_req_core, timeout_err, proto_err}, '0);
        tick();
        reset = 1'b1;
        seen  = 0;
        for (int unsigned i = 0; i < TO + 4; i++) begin
            tick();
            if (core_ready != '0 || fp_req_valid) seen++;
        end
        check("ar_dropped", seen, 0);
        set_req(0, 8'h50);
        set_req(3, 8'h53);
        tick();
        core_req = '0;
        tick();
        check("ar_restart_core0", {fp_req_valid, fp_req_core, fp_req_id}, {1'b1, 2'd0, 8'h50});

        // ---------------- randomized run against reference model ----------------
        do_reset();
        m_pend     = '0;
        m_rr       = 0;
        in_issue   = 1'b0;
        have_exp   = 1'b0;
        resp_sched = 1'b0;
        prev_v     = 1'b0;
        exp_terr   = 1'b0;
        exp_perr   = 1'b0;
        served     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            m_id[i]    = '0;
            m_latch[i] = 0;
        end
        for (int unsigned cyc = 0; cyc < 2600; cyc++) begin
            exp_rdy = '0;
            exp_dat = '0;
            if (have_exp && edge_n == exp_edge) begin
                exp_rdy = onehot(exp_core);
                exp_dat = exp_data;
                if (exp_to) exp_terr = 1'b1;
                m_pend[exp_core] = 1'b0;
                m_rr     = (exp_core + 1) % N;
                have_exp = 1'b0;
                served++;
            end
            check("rnd_ready", core_ready, exp_rdy);
            check("rnd_data", core_data, exp_dat);
            check("rnd_terr", timeout_err, exp_terr);
            check("rnd_perr", proto_err, exp_perr);

            if (fp_req_valid && !prev_v) begin
                // Grant decided in the cycle before valid rose: only requests
                // latched at least one edge earlier are visible to it.
                found = 1'b0;
                exp_c = 0;
                for (int unsigned k = 0; k < N; k++) begin
                    cc = (m_rr + k) % N;
                    if (!found && m_pend[cc] && m_latch[cc] <= edge_n - 1) begin
                        found = 1'b1;
                        exp_c = cc;
                    end
                end
                check("rnd_eligible", found, 1'b1);
                check("rnd_core", fp_req_core, 2'(exp_c));
                check("rnd_id", fp_req_id, m_id[exp_c]);
                cur      = exp_c;
                in_issue = 1'b1;
            end else if (in_issue) begin
                check("rnd_hold", {fp_req_valid, fp_req_core, fp_req_id}, {1'b1, 2'(cur), m_id[cur]});
            end else begin
                check("rnd_valid_low", fp_req_valid, 1'b0);
            end
            prev_v = fp_req_valid;

            fp_resp_valid = 1'b0;
            core_req      = '0;
            if (in_issue) begin
                fp_req_ready = ($urandom_range(0, 2) != 0);
                if (fp_req_ready) begin
                    in_issue = 1'b0;
                    have_exp = 1'b1;
                    exp_core = cur;
                    d = $urandom_range(1, TO + 2);
                    if (d <= TO) begin
                        resp_sched = 1'b1;
                        resp_val   = $urandom;
                        resp_edge  = edge_n + 1 + d;
                        exp_edge   = edge_n + 1 + d;
                        exp_data   = resp_val;
                        exp_to     = 1'b0;
                    end else begin
                        exp_edge = edge_n + 1 + TO;
                        exp_data = '1;
                        exp_to   = 1'b1;
                    end
                end
            end else begin
                fp_req_ready = $urandom_range(0, 1) != 0;
            end
            if (resp_sched && resp_edge == edge_n + 1) begin
                fp_resp_valid = 1'b1;
                fp_resp_data  = resp_val;
                resp_sched    = 1'b0;
            end
            if (cyc < 2200) begin
                for (int unsigned c = 0; c < N; c++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        nid = FW'($urandom);
                        if (m_pend[c]) begin
                            if (cyc >= 1800) begin
                                set_req(c, nid);
                                exp_perr = 1'b1;
                            end
                        end else begin
                            set_req(c, nid);
                            m_pend[c]  = 1'b1;
                            m_id[c]    = nid;
                            m_latch[c] = edge_n + 1;
                        end
                    end
                end
            end
            tick();
        end
        fp_resp_valid = 1'b0;
        core_req      = '0;
        check("rnd_drain_pending", m_pend, '0);
        check("rnd_drain_txn", have_exp, 1'b0);
        check("rnd_served_min", served >= 50, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
